// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754-style floating-point multiplier.
// Operands are unpacked and classified, significands are multiplied one
// bit per cycle with a radix-2 shift-add, and the product is normalised and
// rounded to nearest-even with gradual underflow. Special operand pairs
// (zero, infinity, NaN) bypass the multiplier and finish two edges after accept.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  output logic                 o_valid,
  output logic [EXP_W+MAN_W:0] o_res,
  output logic [3:0]           o_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;   // operand width
  localparam int SW   = MAN_W + 1;           // significand width incl. hidden bit
  localparam int PW   = 2 * SW;              // full product width
  localparam int XW   = EXP_W + 2;           // signed internal exponent width
  localparam int CW   = $clog2(SW + 1);      // bit counter / leading-zero count width
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;    // all-ones exponent field

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_ROUND,
    S_DONE
  } state_t;

  // Classified operand with its significand already normalised so the
  // leading one sits at bit MAN_W, and its exponent unbiased-by-field.
  typedef struct packed {
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 snan;
    logic signed [XW-1:0] exp;
    logic [SW-1:0]        sig;
  } operand_t;

  // Leading zeros of a significand; SW when the value is zero.
  function automatic logic [CW-1:0] lzc(input logic [SW-1:0] v);
    logic [CW-1:0] n;
    n = CW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = CW'(SW - 1 - i);
    end
    return n;
  endfunction

  function automatic operand_t unpack(input logic [W-1:0] v);
    operand_t             u;
    logic [EXP_W-1:0]     e;
    logic [MAN_W-1:0]     f;
    logic [CW-1:0]        lz;
    e      = v[W-2:MAN_W];
    f      = v[MAN_W-1:0];
    u      = '0;
    u.zero = (e == '0) && (f == '0);
    u.inf  = (&e) && (f == '0);
    u.nan  = (&e) && (f != '0);
    u.snan = u.nan && !f[MAN_W-1];
    if (e == '0) begin
      // Subnormal: shift the leading one up to the hidden position; the
      // field value 0 behaves as exponent 1, hence 1 - count.
      lz    = lzc({1'b0, f});
      u.sig = {1'b0, f} << lz;
      u.exp = XW'(1) - XW'(lz);
    end else begin
      lz    = '0;
      u.sig = {1'b1, f};
      u.exp = XW'(e);
    end
    return u;
  endfunction

  state_t               state, state_nx;
  logic [W-1:0]         a_r, b_r;       // operands captured at accept
  logic signed [XW-1:0] ea_r, eb_r;     // normalised operand exponents
  logic [SW-1:0]        ma_r;           // multiplicand significand
  logic [PW-1:0]        p_r;            // {partial sum, remaining multiplier bits}
  logic [CW-1:0]        cnt_r;          // multiplier bits left to process

  logic                 accept;
  logic                 sgn;

  // Unpack stage signals
  operand_t             ua, ub;
  logic                 special;
  logic [W-1:0]         spec_res;
  logic [3:0]           spec_flags;

  // Multiply step signals
  logic [SW:0]          sum;
  logic [PW-1:0]        p_next;

  // Round stage signals
  logic                 norm;
  logic signed [XW-1:0] e0, e1;
  logic [XW-1:0]        sh;
  logic [SW-1:0]        mant;
  logic                 guard, sticky, lost, round_up, inexact, tiny;
  logic [SW:0]          ext;
  logic [SW:0]          mr;
  logic [W-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

  assign o_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept  = i_valid && o_ready;
  assign sgn     = a_r[W-1] ^ b_r[W-1];

  // Classify the captured operands and form the bypass result for special pairs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    ua         = unpack(a_r);
    ub         = unpack(b_r);
    special    = ua.nan | ub.nan | ua.zero | ub.zero | ua.inf | ub.inf;
    spec_res   = '0;
    spec_flags = '0;
    if (ua.nan || ub.nan || (ua.zero && ub.inf) || (ua.inf && ub.zero)) begin
      spec_res      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags[3] = (ua.zero && ub.inf) || (ua.inf && ub.zero) || ua.snan || ub.snan;
    end else if (ua.inf || ub.inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    sum    = {1'b0, p_r[PW-1:SW]} + (p_r[0] ? {1'b0, ma_r} : {(SW+1){1'b0}});
    p_next = {sum, p_r[SW-1:1]};
  end

  // Normalise, denormalise if tiny, round to nearest-even and detect overflow.
  always_comb begin
    rnd_res   = '0;
    rnd_flags = '0;
    norm      = p_r[PW-1];
    e0        = ea_r + eb_r - XW'(BIAS) + XW'(norm);
    if (norm) begin
      mant   = p_r[PW-1:SW];
      guard  = p_r[SW-1];
      sticky = |p_r[SW-2:0];
    end else begin
      mant   = p_r[PW-2:SW-1];
      guard  = p_r[SW-2];
      sticky = |p_r[SW-3:0];
    end
    tiny = (e0 < 1);
    sh   = XW'(1) - e0;
    ext  = {mant, guard};
    lost = 1'b0;
    if (tiny) begin
      // Shifting by the full width or more clears ext; everything goes to sticky.
      lost   = |(ext & ~({(SW+1){1'b1}} << sh));
      ext    = ext >> sh;
      mant   = ext[SW:1];
      guard  = ext[0];
      sticky = sticky | lost;
    end
    round_up = guard & (sticky | mant[0]);
    mr       = {1'b0, mant} + {{SW{1'b0}}, round_up};
    inexact  = guard | sticky;
    e1       = e0 + XW'(mr[SW]);
    if (tiny) begin
      // A subnormal that rounds into the hidden bit becomes the minimum normal.
      rnd_res   = {sgn, {(EXP_W-1){1'b0}}, mr[MAN_W], mr[MAN_W-1:0]};
      rnd_flags = {2'b00, inexact, inexact};
    end else if (e1 >= EMAX) begin
      rnd_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else begin
      rnd_res   = {sgn, e1[EXP_W-1:0], mr[MAN_W-1:0]};
      rnd_flags = {3'b000, inexact};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_UNPACK;
      S_UNPACK: state_nx = special ? S_DONE : S_MULT;
      S_MULT:   if (cnt_r == '0) state_nx = S_ROUND;
      S_ROUND:  state_nx = S_DONE;
      S_DONE:   if (accept) state_nx = S_UNPACK;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_r     <= '0;
      b_r     <= '0;
      ea_r    <= '0;
      eb_r    <= '0;
      ma_r    <= '0;
      p_r     <= '0;
      cnt_r   <= '0;
      o_valid <= 1'b0;
      o_res   <= '0;
      o_flags <= '0;
    end else begin
      if (accept) begin
        a_r     <= i_a;
        b_r     <= i_b;
        o_valid <= 1'b0;
      end
      case (state)
        S_UNPACK: begin
          if (special) begin
            o_res   <= spec_res;
            o_flags <= spec_flags;
            o_valid <= 1'b1;
          end else begin
            ea_r  <= ua.exp;
            eb_r  <= ub.exp;
            ma_r  <= ua.sig;
            p_r   <= {{SW{1'b0}}, ub.sig};
            cnt_r <= CW'(MAN_W);
          end
        end
        S_MULT: begin
          p_r   <= p_next;
          cnt_r <= cnt_r - 1'b1;
        end
        S_ROUND: begin
          o_res   <= rnd_res;
          o_flags <= rnd_flags;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard bench for fp_mul_seq at single precision
// (EXP_W=8, MAN_W=23) and half precision (EXP_W=5, MAN_W=10). A driver
// issues directed operand pairs and queues hand-computed results; one
// monitor per instance pops and compares whenever o_valid rises.
module tb_fp_mul_seq;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        v32 = 1'b0, rdy32, ov32;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [3:0]  fl32;

  logic        v16 = 1'b0, rdy16, ov16;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  fl16;

  exp_t q32[$];
  exp_t q16[$];

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(rdy32),
    .i_a(a32), .i_b(b32), .o_valid(ov32), .o_res(res32), .o_flags(fl32)
  );

  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16),
    .i_a(a16), .i_b(b16), .o_valid(ov16), .o_res(res16), .o_flags(fl16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Wait for ready, present one operand pair, record the accept edge and queue the expectation.
  task automatic issue(input bit is16, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] fl, input int lat,
                       input string nm, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(is16 ? rdy16 : rdy32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({nm, "_ready_timeout"}, 32'(is16 ? rdy16 : rdy32), 32'd1);
    if (is16) begin
      v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      v32 = 1'b1; a32 = a; b32 = b;
    end
    @(posedge clk);
    #1;
    e = '{res: res, flags: fl, lat: lat, acc: cyc, name: nm};
    if (push) begin
      if (is16) q16.push_back(e);
      else      q32.push_back(e);
    end
    // Scramble operand buses while the operation runs.
    v32 = 1'b0;
    v16 = 1'b0;
    a32 = $urandom();
    b32 = $urandom();
    a16 = 16'($urandom());
    b16 = 16'($urandom());
  endtask

  // Single-precision monitor.
  initial begin : mon32
    exp_t        e;
    bit          prev;
    logic [31:0] held_res;
    logic [3:0]  held_fl;
    prev = 1'b0; held_res = '0; held_fl = '0;
    forever begin
      @(negedge clk);
      if (!rst && ov32 && !prev) begin
        if (q32.size() == 0) begin
          check("unexpected_valid32", 32'(ov32), 32'd0);
          held_res = res32; held_fl = fl32;
        end else begin
          e = q32.pop_front();
          check({e.name, "_res"}, res32, e.res);
          check({e.name, "_flags"}, 32'(fl32), 32'(e.flags));
          check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          held_res = e.res; held_fl = e.flags;
        end
      end else if (!rst && ov32 && prev) begin
        check("hold32_res", res32, held_res);
        check("hold32_flags", 32'(fl32), 32'(held_fl));
      end
      prev = ov32;
    end
  end

  // Half-precision monitor.
  initial begin : mon16
    exp_t        e;
    bit          prev;
    logic [15:0] held_res;
    prev = 1'b0; held_res = '0;
    forever begin
      @(negedge clk);
      if (!rst && ov16 && !prev) begin
        if (q16.size() == 0) begin
          check("unexpected_valid16", 32'(ov16), 32'd0);
          held_res = res16;
        end else begin
          e = q16.pop_front();
          check({e.name, "_res"}, 32'(res16), e.res);
          check({e.name, "_flags"}, 32'(fl16), 32'(e.flags));
          check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          held_res = e.res[15:0];
        end
      end else if (!rst && ov16 && prev) begin
        check("hold16_res", 32'(res16), 32'(held_res));
      end
      prev = ov16;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid32", 32'(ov32), 32'd0);
    check("rst_res32", res32, 32'd0);
    check("rst_flags32", 32'(fl32), 32'd0);
    check("rst_ready32", 32'(rdy32), 32'd1);
    check("rst_valid16", 32'(ov16), 32'd0);
    check("rst_ready16", 32'(rdy16), 32'd1);
    rst = 1'b0;

    // Single precision: consecutive issues run back-to-back through DONE.
    issue(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, "mul_1p5_2", 1);
    issue(0, 32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000,  2, "zero_inf", 1);
    issue(0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 27, "overflow", 1);
    issue(0, 32'h00000001, 32'h3F000000, 32'h00000000, 4'b0011, 27, "tie_to_zero", 1);
    issue(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27, "sticky_inexact", 1);
    issue(0, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 27, "neg_3x2", 1);
    issue(0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 27, "norm_shift", 1);
    issue(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 27, "tie_up_even", 1);
    issue(0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000,  2, "snan", 1);
    issue(0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000,  2, "qnan", 1);
    issue(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  2, "inf_fin", 1);
    issue(0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000,  2, "negzero_fin", 1);
    issue(0, 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000,  2, "inf_inf", 1);
    issue(0, 32'h00400000, 32'h40000000, 32'h00800000, 4'b0000, 27, "sub_to_normal", 1);
    issue(0, 32'h007FFFFF, 32'h3F800001, 32'h00800000, 4'b0011, 27, "sub_round_min", 1);

    // Reset in the middle of an operation: nothing may be emitted.
    issue(0, 32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000, 27, "aborted", 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(ov32), 32'd0);
    check("abort_res", res32, 32'd0);
    check("abort_flags", 32'(fl32), 32'd0);
    check("abort_ready", 32'(rdy32), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 27, "after_reset", 1);

    // Half precision
    issue(1, 32'h3C00, 32'h4000, 32'h4000, 4'b0000, 14, "h_mul_1_2", 1);
    issue(1, 32'h0001, 32'h3800, 32'h0000, 4'b0011, 14, "h_tie_to_zero", 1);
    issue(1, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000,  2, "h_inf_zero", 1);
    issue(1, 32'h4200, 32'hC000, 32'hC600, 4'b0000, 14, "h_neg_3x2", 1);
    issue(1, 32'h7BFF, 32'h4000, 32'h7C00, 4'b0101, 14, "h_overflow", 1);

    // Let both scoreboards drain; anything left behind is a lost result.
    n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pending32", 32'(q32.size()), 32'd0);
    check("pending16", 32'(q16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
